// File: rtl/mac_vec.sv
// mac_vec: pipelined multiply-accumulate over LEN-element vectors.
// Stage 1 registers the product of each accepted sample; stage 2 folds it
// into a saturating accumulator and publishes the result on the last element.
module mac_vec #(
  parameter int DW     = 8,
  parameter int AW     = 20,
  parameter int LEN    = 4,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic [AW-1:0] dout,
  output logic          out_valid,
  output logic          ovf
);

  localparam int            CW       = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  logic [CW-1:0]   count_q, count_d;
  logic [2*DW-1:0] a_ext, b_ext, prod_d, p_q;
  logic            p_valid_q, p_first_q, p_last_q;
  logic [AW:0]     p_ext, acc_ext, sum;
  logic [AW-1:0]   acc_q, acc_d, dout_q;
  logic            clamp_d, run_ovf_q, ovf_q, out_valid_q;

  // Stage 1 next-state: operands widened to 2*DW so the low half of the
  // product is correct for both signed and unsigned interpretation.
  always_comb begin
    a_ext   = (SIGNED != 0) ? {{DW{din0[DW-1]}}, din0} : {{DW{1'b0}}, din0};
    b_ext   = (SIGNED != 0) ? {{DW{din1[DW-1]}}, din1} : {{DW{1'b0}}, din1};
    prod_d  = a_ext * b_ext;
    count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
  end

  // Stage 2 next-state: one guard bit above AW detects overflow of the sum.
  always_comb begin
    p_ext   = (SIGNED != 0) ? {{(AW+1-2*DW){p_q[2*DW-1]}}, p_q}
                            : {{(AW+1-2*DW){1'b0}}, p_q};
    acc_ext = (SIGNED != 0) ? {acc_q[AW-1], acc_q} : {1'b0, acc_q};
    sum     = acc_ext + p_ext;
    clamp_d = 1'b0;
    acc_d   = sum[AW-1:0];
    if (p_first_q) begin
      acc_d = p_ext[AW-1:0];
    end else if (SIGNED != 0) begin
      if (sum[AW] != sum[AW-1]) begin
        clamp_d = 1'b1;
        acc_d   = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
    end else if (sum[AW]) begin
      clamp_d = 1'b1;
      acc_d   = '1;
    end
  end

  // Pipeline registers; clr flushes the vector in progress but keeps dout/ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      run_ovf_q   <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr) begin
        count_q   <= '0;
        p_valid_q <= 1'b0;
        acc_q     <= '0;
        run_ovf_q <= 1'b0;
      end else begin
        if (in_valid) begin
          p_q       <= prod_d;
          p_valid_q <= 1'b1;
          p_first_q <= (count_q == '0);
          p_last_q  <= (count_q == CNT_LAST);
          count_q   <= count_d;
        end else begin
          p_valid_q <= 1'b0;
        end
        if (p_valid_q) begin
          acc_q <= acc_d;
          if (p_last_q) begin
            dout_q      <= acc_d;
            ovf_q       <= run_ovf_q | clamp_d;
            out_valid_q <= 1'b1;
            run_ovf_q   <= 1'b0;
          end else begin
            run_ovf_q <= run_ovf_q | clamp_d;
          end
        end
      end
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_vec.sv
// Bench for mac_vec: five parameterisations share one stimulus stream; a
// per-instance reference model pushes expected completions into queues that
// a negedge monitor pops when out_valid fires.
module tb_mac_vec;

  localparam int NI = 5;

  typedef struct {
    int          cyc;
    logic [19:0] dout;
    logic        ovf;
  } exp_t;

  logic       clk, rst, clr, in_valid;
  logic [7:0] din0, din1;
  int         cyc;
  int         checks, errors;

  logic [19:0] dout0, dout2, dout4;
  logic [15:0] dout1, dout3;
  logic [19:0] dout_a [NI];
  logic        ov_a   [NI];
  logic        ovf_a  [NI];

  exp_t        exp_q  [NI][$];
  logic [19:0] hold_d [NI];
  logic        hold_o [NI];

  int     m_cnt [NI];
  longint m_acc [NI];
  bit     m_rovf[NI];
  bit     m_pv  [NI];
  bit     m_pf  [NI];
  bit     m_pl  [NI];
  longint m_pp  [NI];

  mac_vec u0 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din0(din0), .din1(din1),
              .dout(dout0), .out_valid(ov_a[0]), .ovf(ovf_a[0]));
  mac_vec #(.AW(16)) u1 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din0(din0),
              .din1(din1), .dout(dout1), .out_valid(ov_a[1]), .ovf(ovf_a[1]));
  mac_vec #(.SIGNED(1)) u2 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din0(din0),
              .din1(din1), .dout(dout2), .out_valid(ov_a[2]), .ovf(ovf_a[2]));
  mac_vec #(.AW(16), .SIGNED(1)) u3 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
              .din0(din0), .din1(din1), .dout(dout3), .out_valid(ov_a[3]), .ovf(ovf_a[3]));
  mac_vec #(.LEN(1)) u4 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din0(din0),
              .din1(din1), .dout(dout4), .out_valid(ov_a[4]), .ovf(ovf_a[4]));

  assign dout_a[0] = dout0;
  assign dout_a[1] = {4'b0, dout1};
  assign dout_a[2] = dout2;
  assign dout_a[3] = {4'b0, dout3};
  assign dout_a[4] = dout4;

  function automatic int aw_of(input int i);
    return (i == 1 || i == 3) ? 16 : 20;
  endfunction

  function automatic bit sg_of(input int i);
    return (i == 2 || i == 3);
  endfunction

  function automatic int len_of(input int i);
    return (i == 4) ? 1 : 4;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: called just before the edge that will sample the inputs.
  task automatic model_step(input bit iv, input bit c, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < NI; i++) begin
      longint hi, lo, s, mask;
      bit     clampb;
      int     sa, sb;
      exp_t   e;
      mask = (longint'(1) << aw_of(i)) - 1;
      hi   = sg_of(i) ? (longint'(1) << (aw_of(i) - 1)) - 1 : mask;
      lo   = sg_of(i) ? -(longint'(1) << (aw_of(i) - 1)) : 0;
      if (c) begin
        m_cnt[i] = 0; m_acc[i] = 0; m_rovf[i] = 0; m_pv[i] = 0;
        continue;
      end
      if (m_pv[i]) begin
        clampb = 0;
        if (m_pf[i]) m_acc[i] = m_pp[i];
        else begin
          s = m_acc[i] + m_pp[i];
          if (s > hi) begin s = hi; clampb = 1; end
          if (s < lo) begin s = lo; clampb = 1; end
          m_acc[i] = s;
        end
        if (m_pl[i]) begin
          e.cyc  = cyc + 1;
          e.dout = 20'(m_acc[i] & mask);
          e.ovf  = m_rovf[i] | clampb;
          exp_q[i].push_back(e);
          m_rovf[i] = 0;
        end else m_rovf[i] = m_rovf[i] | clampb;
      end
      if (iv) begin
        sa = sg_of(i) ? {{24{a[7]}}, a} : {24'b0, a};
        sb = sg_of(i) ? {{24{b[7]}}, b} : {24'b0, b};
        m_pp[i] = longint'(sa) * longint'(sb);
        m_pf[i] = (m_cnt[i] == 0);
        m_pl[i] = (m_cnt[i] == len_of(i) - 1);
        m_cnt[i] = (m_cnt[i] == len_of(i) - 1) ? 0 : m_cnt[i] + 1;
        m_pv[i] = 1;
      end else m_pv[i] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_acc[i] = 0; m_rovf[i] = 0; m_pv[i] = 0;
      m_pf[i] = 0; m_pl[i] = 0; m_pp[i] = 0;
      hold_d[i] = '0; hold_o[i] = 1'b0;
      exp_q[i].delete();
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input bit iv, input bit c, input logic [7:0] a, input logic [7:0] b);
    in_valid = iv; clr = c; din0 = a; din1 = b;
    model_step(iv, c, a, b);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d rst dout", i), dout_a[i], 0);
      check($sformatf("u%0d rst out_valid", i), ov_a[i], 0);
      check($sformatf("u%0d rst ovf", i), ovf_a[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Monitor: pop on out_valid, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      if (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
        e = exp_q[i].pop_front();
        check($sformatf("u%0d missed out_valid at cyc", i), cyc, e.cyc);
      end
      if (ov_a[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("u%0d unexpected out_valid", i), ov_a[i], 0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("u%0d out cyc", i), cyc, e.cyc);
          check($sformatf("u%0d dout", i), dout_a[i], e.dout);
          check($sformatf("u%0d ovf", i), ovf_a[i], e.ovf);
          hold_d[i] = e.dout;
          hold_o[i] = e.ovf;
        end
      end else begin
        check($sformatf("u%0d dout hold", i), dout_a[i], hold_d[i]);
        check($sformatf("u%0d ovf hold", i), ovf_a[i], hold_o[i]);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d init dout", i), dout_a[i], 0);
      check($sformatf("u%0d init out_valid", i), ov_a[i], 0);
    end
    rst = 1'b1;

    // Back-to-back vectors of (4,3).
    repeat (8) step(1'b1, 1'b0, 8'd4, 8'd3);
    idle(3);
    check("t1 u0 dout", dout_a[0], 48);
    check("t1 u0 ovf", ovf_a[0], 0);
    check("t1 u4 dout", dout_a[4], 12);

    // Gapped samples.
    step(1'b1, 1'b0, 8'd1, 8'd2); idle(2);
    step(1'b1, 1'b0, 8'd3, 8'd4); idle(2);
    step(1'b1, 1'b0, 8'd5, 8'd6); idle(2);
    step(1'b1, 1'b0, 8'd7, 8'd8); idle(3);
    check("t2 u0 dout", dout_a[0], 100);
    check("t2 u4 dout", dout_a[4], 56);
    idle(4);
    check("t2 u0 dout held", dout_a[0], 100);

    // Unsigned saturation, then recovery.
    repeat (4) step(1'b1, 1'b0, 8'd255, 8'd255);
    idle(3);
    check("t3 u1 dout", dout_a[1], 65535);
    check("t3 u1 ovf", ovf_a[1], 1);
    check("t3 u0 dout", dout_a[0], 260100);
    repeat (4) step(1'b1, 1'b0, 8'd1, 8'd1);
    idle(3);
    check("t3b u1 dout", dout_a[1], 4);
    check("t3b u1 ovf", ovf_a[1], 0);

    // Signed arithmetic and negative clamp.
    repeat (4) step(1'b1, 1'b0, 8'hFD, 8'd5);
    idle(3);
    check("t4 u2 dout", dout_a[2], 20'hFFFC4);
    check("t4 u2 ovf", ovf_a[2], 0);
    repeat (4) step(1'b1, 1'b0, 8'h80, 8'h7F);
    idle(3);
    check("t4b u3 dout", dout_a[3], 16'h8000);
    check("t4b u3 ovf", ovf_a[3], 1);

    // Clear mid-vector, concurrent with a sample.
    repeat (2) step(1'b1, 1'b0, 8'd4, 8'd3);
    step(1'b1, 1'b1, 8'd4, 8'd3);
    check("t5 u0 dout through clr", dout_a[0], 65024);
    repeat (4) step(1'b1, 1'b0, 8'd2, 8'd2);
    idle(3);
    check("t5 u0 dout", dout_a[0], 16);

    // Reset mid-vector.
    repeat (3) step(1'b1, 1'b0, 8'd4, 8'd3);
    do_reset();
    repeat (4) step(1'b1, 1'b0, 8'd1, 8'd1);
    idle(3);
    check("t6 u0 dout", dout_a[0], 4);
    check("t6 u4 dout", dout_a[4], 1);

    idle(2);
    for (int i = 0; i < NI; i++)
      check($sformatf("u%0d pending results", i), exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
